// File: rtl/mips_mem_dump_ctrl.sv
// BRAM port owner shared by the MIPS CPU and the memory-dump streamer.
// A halt store or dump_start stalls the CPU and streams every BRAM word out.
module mips_mem_dump_ctrl #(
    parameter int          ADDR_W    = 12,
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] HALT_ADDR = 32'h0000000C
) (
    input  logic              mips_cpu_clk,
    input  logic              mips_cpu_reset,
    input  logic [31:0]       cpu_mem_addr,
    input  logic [31:0]       cpu_mem_wdata,
    input  logic              cpu_mem_write,
    input  logic              cpu_mem_read,
    output logic [31:0]       cpu_mem_rdata,
    output logic              cpu_stall,
    input  logic              dump_start,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_wdata,
    input  logic [31:0]       bram_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [31:0]       dump_data,
    output logic              dump_last,
    output logic              dump_done
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              armed_q, armed_d;
    logic              stall_q, stall_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              trigger_s;

    // The halt store only counts while armed; dump_start is ANDed with IDLE below.
    assign trigger_s = (armed_q & cpu_mem_write & (cpu_mem_addr == HALT_ADDR) &
                        (cpu_mem_wdata == 32'h0000_0000)) | dump_start;

    // State and output registers with synchronous reset.
    always_ff @(posedge mips_cpu_clk) begin
        if (mips_cpu_reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            armed_q <= 1'b1;
            stall_q <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= 32'h0000_0000;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            armed_q <= armed_d;
            stall_q <= stall_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic for the dump sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        armed_d = armed_q;
        stall_d = stall_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (trigger_s) begin
                    state_d = S_RD;
                    stall_d = 1'b1;
                    armed_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                data_d  = bram_rdata;
                addr_d  = ptr_q;
                last_d  = (ptr_q == LAST_PTR);
                valid_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (dump_ready) begin
                    valid_d = 1'b0;
                    if (ptr_q == LAST_PTR) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d   = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                stall_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // BRAM port mux: CPU passthrough in IDLE, sequencer pointer otherwise.
    always_comb begin
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = ptr_q;
        bram_wdata = 32'h0000_0000;
        if (state_q == S_IDLE) begin
            bram_en    = cpu_mem_read | cpu_mem_write;
            bram_we    = cpu_mem_write;
            bram_addr  = cpu_mem_addr[ADDR_W+1:2];
            bram_wdata = cpu_mem_wdata;
        end else begin
            bram_en = (state_q == S_RD);
        end
    end

    assign cpu_mem_rdata = bram_rdata;
    assign cpu_stall     = stall_q;
    assign dump_valid    = valid_q;
    assign dump_addr     = addr_q;
    assign dump_data     = data_q;
    assign dump_last     = last_q;
    assign dump_done     = done_q;

endmodule

// File: tb/tb_mips_mem_dump_ctrl.sv
// Randomized bench for mips_mem_dump_ctrl: BRAM model, behavioural dump-stream
// reference model, per-cycle compare process and directed literal checks.
module tb_mips_mem_dump_ctrl;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dump_start = 1'b0;
    logic        bram_en, bram_we;
    logic [11:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [11:0] dump_addr;
    logic [31:0] dump_data;
    logic        dump_last, dump_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic preload = 1'b1;
    logic chk_en  = 1'b0;

    always #5 clk = ~clk;

    mips_mem_dump_ctrl dut (
        .mips_cpu_clk(clk), .mips_cpu_reset(rst),
        .cpu_mem_addr(cpu_addr), .cpu_mem_wdata(cpu_wdata),
        .cpu_mem_write(cpu_we), .cpu_mem_read(cpu_re),
        .cpu_mem_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dump_start(dump_start),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_last(dump_last), .dump_done(dump_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous single-port BRAM, one-cycle read latency.
    logic [31:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= 32'(k * 3);
        end else if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_wdata;
            bram_rdata <= mem[bram_addr];
        end
    end

    // Reference model: memory image plus dump-stream timing (word every 3 cycles).
    typedef enum int {M_IDLE, M_RUN, M_DONE} mmode_t;
    mmode_t      m_mode  = M_IDLE;
    logic [31:0] ref_mem [0:DEPTH-1];
    int          m_idx   = 0;
    int          m_cnt   = 0;
    logic        m_valid = 1'b0, m_stall = 1'b0, m_done = 1'b0, m_last = 1'b0;
    logic [11:0] m_addr  = 12'h0;
    logic [31:0] m_data  = 32'h0;

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < DEPTH; k++) ref_mem[k] <= 32'(k * 3);
        end
        if (rst) begin
            m_mode <= M_IDLE; m_valid <= 1'b0; m_stall <= 1'b0; m_done <= 1'b0;
            m_last <= 1'b0; m_addr <= 12'h0; m_data <= 32'h0; m_idx <= 0; m_cnt <= 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (cpu_we && !preload) ref_mem[cpu_addr[13:2]] <= cpu_wdata;
                    if ((cpu_we && cpu_addr == 32'h0000000C && cpu_wdata == 32'h0) || dump_start) begin
                        m_mode <= M_RUN; m_stall <= 1'b1; m_idx <= 0; m_cnt <= 2;
                    end
                end
                M_RUN: begin
                    if (m_valid) begin
                        if (dump_ready) begin
                            m_valid <= 1'b0;
                            if (m_idx == DEPTH - 1) begin
                                m_mode <= M_DONE; m_done <= 1'b1;
                            end else begin
                                m_idx <= m_idx + 1; m_cnt <= 2;
                            end
                        end
                    end else if (m_cnt == 1) begin
                        m_valid <= 1'b1;
                        m_addr  <= 12'(m_idx);
                        m_data  <= ref_mem[m_idx];
                        m_last  <= (m_idx == DEPTH - 1);
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    int obs_hs = 0, obs_last = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_stall", 32'(cpu_stall), 32'(m_stall));
            chk("dump_valid", 32'(dump_valid), 32'(m_valid));
            chk("dump_done", 32'(dump_done), 32'(m_done));
            chk("dump_addr", 32'(dump_addr), 32'(m_addr));
            chk("dump_data", dump_data, m_data);
            chk("dump_last", 32'(dump_last), 32'(m_last));
            if (m_mode == M_IDLE) begin
                chk("bram_en_idle", 32'(bram_en), 32'(cpu_re | cpu_we));
                chk("bram_we_idle", 32'(bram_we), 32'(cpu_we));
                chk("bram_addr_idle", 32'(bram_addr), 32'(cpu_addr[13:2]));
                if (cpu_we) chk("bram_wdata_idle", bram_wdata, cpu_wdata);
            end else begin
                chk("bram_we_busy", 32'(bram_we), 32'h0);
                chk("bram_en_busy", 32'(bram_en), 32'(m_mode == M_RUN && !m_valid && m_cnt == 2));
                chk("bram_addr_busy", 32'(bram_addr), 32'(m_idx));
            end
            if (dump_valid && dump_ready) begin
                obs_hs++;
                if (dump_last) obs_last++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cpu();
        cpu_addr  = $urandom & 32'h0000_3FFC;
        cpu_wdata = $urandom | 32'h1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_re    = !cpu_we && ($urandom_range(0, 1) == 1);
    endtask

    int   n, hs0, last0, lat;
    logic froze;

    initial begin
        cyc(); preload = 1'b0;
        cyc(); cyc();
        rst = 1'b0; chk_en = 1'b1;
        chk("rst_valid", 32'(dump_valid), 32'h0);
        chk("rst_stall", 32'(cpu_stall), 32'h0);
        chk("rst_done", 32'(dump_done), 32'h0);
        chk("rst_addr", 32'(dump_addr), 32'h0);
        chk("rst_data", dump_data, 32'h0);

        // IDLE passthrough store then load.
        cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF; cpu_we = 1'b1; #1;
        chk("pt_we", 32'(bram_we), 32'h1);
        chk("pt_addr", 32'(bram_addr), 32'h010);
        cyc(); cpu_we = 1'b0; cpu_re = 1'b1; #1;
        chk("pt_we_load", 32'(bram_we), 32'h0);
        cyc(); cpu_re = 1'b0; #1;
        chk("pt_rdata", cpu_rdata, 32'hDEADBEEF);

        // Non-zero store to the halt address and zero store elsewhere: no trigger.
        cpu_addr = 32'hC; cpu_wdata = 32'd5; cpu_we = 1'b1;
        cyc(); cpu_addr = 32'h10; cpu_wdata = 32'd0;
        cyc(); cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'hC;
        cyc(); cpu_addr = 32'h10; #1;
        chk("no_trig_word3", cpu_rdata, 32'd5);
        cyc(); cpu_re = 1'b0; #1;
        chk("no_trig_word4", cpu_rdata, 32'd0);
        chk("no_trig_stall", 32'(cpu_stall), 32'h0);

        repeat (200) begin rand_cpu(); cyc(); end
        cpu_we = 1'b0; cpu_re = 1'b0;

        // Manual dump, reset at word 100, restart from address 0.
        dump_start = 1'b1; cyc(); dump_start = 1'b0; dump_ready = 1'b1;
        n = 0;
        while (!(dump_valid && dump_addr == 12'd100) && n < 1000) begin rand_cpu(); cyc(); n++; end
        chk("reach_word100", 32'(n < 1000), 32'h1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("midrst_valid", 32'(dump_valid), 32'h0);
        chk("midrst_stall", 32'(cpu_stall), 32'h0);
        chk("midrst_addr", 32'(dump_addr), 32'h0);
        chk("midrst_data", dump_data, 32'h0);
        cpu_we = 1'b0; cpu_re = 1'b0;
        dump_start = 1'b1; cyc(); dump_start = 1'b0;
        lat = 0;
        while (!dump_valid && lat < 10) begin cyc(); lat++; end
        chk("restart_latency", 32'(lat), 32'd2);
        chk("restart_addr", 32'(dump_addr), 32'h0);
        rst = 1'b1; cyc(); rst = 1'b0;

        // Fresh image, then halt store triggers the full dump.
        dump_ready = 1'b0; preload = 1'b1; cyc(); preload = 1'b0;
        hs0 = obs_hs; last0 = obs_last;
        cpu_addr = 32'hC; cpu_wdata = 32'h0; cpu_we = 1'b1;
        cyc(); cpu_we = 1'b0;
        chk("halt_stall", 32'(cpu_stall), 32'h1);
        n = 0; froze = 1'b0;
        while (!dump_done && n < 40000) begin
            rand_cpu();
            if (dump_valid && dump_addr == 12'd3) chk("word3_zero", dump_data, 32'h0);
            if (dump_valid && dump_addr == 12'd7 && !froze) begin
                froze = 1'b1; dump_ready = 1'b0;
                repeat (10) begin cyc(); rand_cpu(); n++; end
                chk("freeze_valid", 32'(dump_valid), 32'h1);
                chk("freeze_addr", 32'(dump_addr), 32'd7);
                chk("freeze_data", dump_data, 32'd21);
            end
            dump_ready = ($urandom_range(0, 3) != 0);
            cyc(); n++;
        end
        chk("dump_complete", 32'(dump_done), 32'h1);
        chk("handshakes", 32'(obs_hs - hs0), 32'd4096);
        chk("last_count", 32'(obs_last - last0), 32'd1);

        // Triggers and stores in DONE are ignored.
        cpu_addr = 32'hC; cpu_wdata = 32'h0; cpu_we = 1'b1; dump_start = 1'b1;
        cyc(); cpu_addr = 32'h20; cpu_wdata = 32'h1234; dump_start = 1'b0;
        cyc(); cpu_we = 1'b0;
        repeat (5) cyc();
        chk("done_sticky", 32'(dump_done), 32'h1);
        chk("done_no_valid", 32'(dump_valid), 32'h0);
        chk("done_stall", 32'(cpu_stall), 32'h1);
        chk("done_no_write", mem[8], 32'd24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
